// File: rtl/pe_stream_feeder_pkg.sv
// Shared constants and types for the PE input-stream feeder: config field layout,
// FIFO tag encodings and the sequencer state encoding.
package pe_stream_feeder_pkg;

  localparam int DATA_BITS   = 32;
  localparam int CONFIG_SIZE = 12;

  localparam int CFG_P_LSB = 10;
  localparam int CFG_P_W   = 2;
  localparam int CFG_Q_LSB = 8;
  localparam int CFG_Q_W   = 2;
  localparam int CFG_F_LSB = 0;
  localparam int CFG_F_W   = 8;

  localparam int CNT_W      = 9;
  localparam int FIFO_CNT_W = 2;

  localparam logic TAG_FILT  = 1'b0;
  localparam logic TAG_IFMAP = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILT  = 2'd1,
    ST_IF    = 2'd2,
    ST_DRAIN = 2'd3
  } feeder_state_e;

  typedef struct packed {
    logic [CFG_P_W-1:0] p;
    logic [CFG_Q_W-1:0] q;
    logic [CFG_F_W-1:0] f;
  } feeder_cfg_t;

endpackage

// File: rtl/pe_stream_feeder_skid_fifo.sv
// Two-entry skid FIFO holding tagged GLB read data until the PE accepts it.
// Push and pop in the same cycle are both honoured; the head is always mem_q[rd_ptr_q].
module feeder_skid_fifo
  import pe_stream_feeder_pkg::*;
#(
  parameter int WIDTH = 33,
  parameter int DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [WIDTH-1:0]      push_data,
  input  logic                  pop,
  output logic [WIDTH-1:0]      head_data,
  output logic [FIFO_CNT_W-1:0] count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0]      mem_q [DEPTH];
  logic [WIDTH-1:0]      mem_d [DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [FIFO_CNT_W-1:0] count_q, count_d;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Payload storage carries no reset; occupancy alone decides what is visible.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign head_data = mem_q[rd_ptr_q];
  assign count     = count_q;

endmodule

// File: rtl/pe_stream_feeder.sv
// PE input-stream feeder: reads filter words then ifmap words from the GLB and
// streams them to one PE over valid/ready through a two-entry skid FIFO.
module pe_stream_feeder #(
  parameter int ADDR_W     = 16,
  parameter int DATA_BITS  = pe_stream_feeder_pkg::DATA_BITS,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic                                       start,
  input  logic [pe_stream_feeder_pkg::CONFIG_SIZE-1:0] i_config,
  input  logic [ADDR_W-1:0]                          filt_base,
  input  logic [ADDR_W-1:0]                          ifmap_base,
  output logic                                       glb_rd_en,
  output logic [ADDR_W-1:0]                          glb_addr,
  input  logic [DATA_BITS-1:0]                       glb_rdata,
  output logic [DATA_BITS-1:0]                       filter,
  output logic                                       filter_valid,
  input  logic                                       filter_ready,
  output logic [DATA_BITS-1:0]                       ifmap,
  output logic                                       ifmap_valid,
  input  logic                                       ifmap_ready,
  output logic                                       busy,
  output logic                                       done
);

  import pe_stream_feeder_pkg::*;

  feeder_state_e         state_q, state_d;
  feeder_cfg_t           cfg_q, cfg_d;
  logic [ADDR_W-1:0]     filt_base_q, filt_base_d;
  logic [ADDR_W-1:0]     ifmap_base_q, ifmap_base_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  inflight_q, inflight_d;
  logic                  inflight_tag_q, inflight_tag_d;

  logic [DATA_BITS:0]    head;
  logic [FIFO_CNT_W-1:0] fifo_count;
  logic                  nonempty;
  logic                  head_tag;
  logic                  pop;
  logic [2:0]            occ;
  logic                  room;
  logic [CNT_W-1:0]      filt_last;
  logic [CNT_W-1:0]      if_last;
  logic                  start_ok;
  logic                  cfg_unused;

  feeder_skid_fifo #(
    .WIDTH (DATA_BITS + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (inflight_q),
    .push_data ({inflight_tag_q, glb_rdata}),
    .pop       (pop),
    .head_data (head),
    .count     (fifo_count)
  );

  assign nonempty     = (fifo_count != '0);
  assign head_tag     = head[DATA_BITS];
  assign filter_valid = nonempty && (head_tag == TAG_FILT);
  assign ifmap_valid  = nonempty && (head_tag == TAG_IFMAP);
  assign filter       = nonempty ? head[DATA_BITS-1:0] : '0;
  assign ifmap        = nonempty ? head[DATA_BITS-1:0] : '0;
  assign pop          = (filter_valid && filter_ready) || (ifmap_valid && ifmap_ready);

  // A new read is allowed only if its data is guaranteed a slot when it returns.
  assign occ  = {1'b0, fifo_count} + {2'b00, inflight_q} - {2'b00, pop};
  assign room = (occ < 3'(FIFO_DEPTH));

  // Index of the last request in each phase: 3*(p+1)-1 and 2+F.
  assign filt_last = CNT_W'(cfg_q.p) + CNT_W'(cfg_q.p) + CNT_W'(cfg_q.p) + CNT_W'(2);
  assign if_last   = CNT_W'(cfg_q.f) + CNT_W'(2);

  // q is carried for the PE-array controller but not used by the read sequence.
  assign cfg_unused = ^cfg_q.q;

  always_comb begin
    state_d        = state_q;
    cfg_d          = cfg_q;
    filt_base_d    = filt_base_q;
    ifmap_base_d   = ifmap_base_q;
    cnt_d          = cnt_q;
    inflight_tag_d = inflight_tag_q;
    glb_rd_en      = 1'b0;
    glb_addr       = '0;
    done           = 1'b0;

    case (state_q)
      ST_IDLE: begin
        state_d = ST_IDLE;
      end
      ST_FILT: begin
        if (room) begin
          glb_rd_en      = 1'b1;
          glb_addr       = filt_base_q + ADDR_W'(cnt_q);
          inflight_tag_d = TAG_FILT;
          if (cnt_q == filt_last) begin
            cnt_d   = '0;
            state_d = ST_IF;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      ST_IF: begin
        if (room) begin
          glb_rd_en      = 1'b1;
          glb_addr       = ifmap_base_q + ADDR_W'(cnt_q);
          inflight_tag_d = TAG_IFMAP;
          if (cnt_q == if_last) begin
            cnt_d   = '0;
            state_d = ST_DRAIN;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      ST_DRAIN: begin
        if (!nonempty && !inflight_q) begin
          done    = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // The done cycle counts as idle so a back-to-back start is not lost.
    start_ok = start && ((state_q == ST_IDLE) || done);
    if (start_ok) begin
      cfg_d.p      = i_config[CFG_P_LSB +: CFG_P_W];
      cfg_d.q      = i_config[CFG_Q_LSB +: CFG_Q_W];
      cfg_d.f      = i_config[CFG_F_LSB +: CFG_F_W];
      filt_base_d  = filt_base;
      ifmap_base_d = ifmap_base;
      cnt_d        = '0;
      state_d      = ST_FILT;
    end
  end

  assign inflight_d = glb_rd_en;
  assign busy       = (state_q != ST_IDLE) && !done;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      cfg_q          <= '0;
      filt_base_q    <= '0;
      ifmap_base_q   <= '0;
      cnt_q          <= '0;
      inflight_q     <= 1'b0;
      inflight_tag_q <= TAG_FILT;
    end else begin
      state_q        <= state_d;
      cfg_q          <= cfg_d;
      filt_base_q    <= filt_base_d;
      ifmap_base_q   <= ifmap_base_d;
      cnt_q          <= cnt_d;
      inflight_q     <= inflight_d;
      inflight_tag_q <= inflight_tag_d;
    end
  end

endmodule

// File: tb/tb_pe_stream_feeder.sv
// Directed bench for pe_stream_feeder: a GLB model returning GLB[a]=a, a negedge
// monitor logging reads and handshakes, and one task per scenario.
module tb_pe_stream_feeder;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [11:0] i_config;
  logic [15:0] filt_base, ifmap_base;
  logic        glb_rd_en;
  logic [15:0] glb_addr;
  logic [31:0] glb_rdata;
  logic [31:0] filter, ifmap;
  logic        filter_valid, filter_ready, ifmap_valid, ifmap_ready;
  logic        busy, done;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  pe_stream_feeder dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .i_config     (i_config),
    .filt_base    (filt_base),
    .ifmap_base   (ifmap_base),
    .glb_rd_en    (glb_rd_en),
    .glb_addr     (glb_addr),
    .glb_rdata    (glb_rdata),
    .filter       (filter),
    .filter_valid (filter_valid),
    .filter_ready (filter_ready),
    .ifmap        (ifmap),
    .ifmap_valid  (ifmap_valid),
    .ifmap_ready  (ifmap_ready),
    .busy         (busy),
    .done         (done)
  );

  // GLB: one-cycle read latency, junk on idle cycles.
  always @(posedge clk) glb_rdata <= glb_rd_en ? {16'h0000, glb_addr} : 32'hDEAD_BEEF;

  logic [15:0] addr_log[$];
  logic [32:0] seq_log[$];
  int          hs_cyc[$];
  int cyc = 0;
  int done_cnt, done_cyc, start_cyc, first_fv_cyc;
  int stab_err, ovf_err, overlap_err;
  logic        pf_v, pi_v, pf_hs, pi_hs;
  logic [31:0] pf_d, pi_d;

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      pf_v = 1'b0; pi_v = 1'b0; pf_hs = 1'b0; pi_hs = 1'b0;
    end else begin
      if (pf_v && !pf_hs && (filter_valid !== 1'b1 || filter !== pf_d)) stab_err++;
      if (pi_v && !pi_hs && (ifmap_valid !== 1'b1 || ifmap !== pi_d)) stab_err++;
      if (filter_valid && ifmap_valid) stab_err++;
      if (glb_rd_en) addr_log.push_back(glb_addr);
      if (filter_valid && filter_ready) begin seq_log.push_back({1'b0, filter}); hs_cyc.push_back(cyc); end
      if (ifmap_valid && ifmap_ready) begin seq_log.push_back({1'b1, ifmap}); hs_cyc.push_back(cyc); end
      if (start && !busy && start_cyc < 0) start_cyc = cyc;
      if (filter_valid && first_fv_cyc < 0) first_fv_cyc = cyc;
      if (done) begin done_cnt++; done_cyc = cyc; if (busy) overlap_err++; end
      if (int'(dut.fifo_count) > 2) ovf_err++;
      pf_v = filter_valid; pf_d = filter; pf_hs = filter_valid && filter_ready;
      pi_v = ifmap_valid;  pi_d = ifmap;  pi_hs = ifmap_valid && ifmap_ready;
    end
  end

  function automatic logic [15:0] exp_addr(input int p, input logic [15:0] fb, input logic [15:0] ib,
                                           input int idx);
    int nf;
    nf = 3 * (p + 1);
    if (idx < nf) return fb + 16'(idx);
    return ib + 16'(idx - nf);
  endfunction

  task automatic clear_logs();
    addr_log.delete(); seq_log.delete(); hs_cyc.delete();
    done_cnt = 0; done_cyc = -1; start_cyc = -1; first_fv_cyc = -1;
    stab_err = 0; ovf_err = 0; overlap_err = 0;
  endtask

  // Runs one job from a posedge+1 entry point until done (or a cycle budget expires).
  task automatic run_job(input int p, input int f, input logic [15:0] fb, input logic [15:0] ib,
                         input bit bp, input bit poke, output bit timeout);
    int d0, n, fh, ih;
    bit fh_done, ih_done;
    clear_logs();
    i_config = {2'(p), 2'b10, 8'(f)}; filt_base = fb; ifmap_base = ib; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    d0 = done_cnt; n = 0; timeout = 1'b0; fh = 0; ih = 0; fh_done = 1'b0; ih_done = 1'b0;
    while (done_cnt == d0 && !timeout) begin
      if (poke && n == 4) begin
        i_config = {2'd1, 2'd0, 8'd9}; filt_base = 16'h0700; ifmap_base = 16'h0800; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      if (bp) begin
        if (seq_log.size() == 5 && !fh_done) begin fh = 10; fh_done = 1'b1; end
        if (seq_log.size() == 15 && !ih_done) begin ih = 10; ih_done = 1'b1; end
        filter_ready = (fh > 0) ? 1'b0 : ($urandom_range(0, 2) != 0);
        ifmap_ready  = (ih > 0) ? 1'b0 : ($urandom_range(0, 2) != 0);
        if (fh > 0) fh--;
        if (ih > 0) ih--;
      end
      @(posedge clk); #1;
      n++;
      if (n > 3000) timeout = 1'b1;
    end
    start = 1'b0; filter_ready = 1'b1; ifmap_ready = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; i_config = '0; filt_base = '0; ifmap_base = '0;
    filter_ready = 1'b1; ifmap_ready = 1'b1;
    clear_logs();
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({glb_rd_en, glb_addr, filter, filter_valid, ifmap, ifmap_valid, busy, done} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got rd=%b addr=%h f=%h fv=%b i=%h iv=%b busy=%b done=%b required all 0",
               glb_rd_en, glb_addr, filter, filter_valid, ifmap, ifmap_valid, busy, done);
    end
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({glb_rd_en, busy, filter_valid, ifmap_valid} !== 4'b0000) begin
      n_fail++;
      $display("FAIL idle_after_reset: got rd=%b busy=%b fv=%b iv=%b required 0", glb_rd_en, busy,
               filter_valid, ifmap_valid);
    end
  endtask

  task automatic test_basic();
    bit to;
    run_job(0, 0, 16'h0010, 16'h0040, 1'b0, 1'b0, to);
    n_checks++; if (to) begin n_fail++; $display("FAIL basic_timeout: got timeout required done"); end
    n_checks++;
    if (addr_log.size() != 6) begin n_fail++; $display("FAIL basic_nreads: got %0d required 6", addr_log.size()); end
    for (int i = 0; i < 6; i++) begin
      n_checks++;
      if (addr_log[i] !== exp_addr(0, 16'h0010, 16'h0040, i)) begin
        n_fail++;
        $display("FAIL basic_addr[%0d]: got %h required %h", i, addr_log[i], exp_addr(0, 16'h0010, 16'h0040, i));
      end
    end
    for (int i = 0; i < 6; i++) begin
      n_checks++;
      if (seq_log[i] !== {1'(i >= 3), 16'h0000, exp_addr(0, 16'h0010, 16'h0040, i)}) begin
        n_fail++;
        $display("FAIL basic_word[%0d]: got %h required %h", i, seq_log[i],
                 {1'(i >= 3), 16'h0000, exp_addr(0, 16'h0010, 16'h0040, i)});
      end
    end
    n_checks++;
    if (first_fv_cyc - start_cyc != 3) begin
      n_fail++; $display("FAIL basic_latency: got %0d required 3", first_fv_cyc - start_cyc);
    end
    n_checks++;
    if (hs_cyc[5] - hs_cyc[0] != 5) begin
      n_fail++; $display("FAIL basic_throughput: got span %0d required 5", hs_cyc[5] - hs_cyc[0]);
    end
    n_checks++;
    if (done_cyc != hs_cyc[5] + 1) begin
      n_fail++; $display("FAIL basic_done_timing: got cycle %0d required %0d", done_cyc, hs_cyc[5] + 1);
    end
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (done_cnt != 1 || busy !== 1'b0 || overlap_err != 0) begin
      n_fail++;
      $display("FAIL basic_done_once: got done_cnt=%0d busy=%b overlap=%0d required 1/0/0", done_cnt, busy, overlap_err);
    end
  endtask

  task automatic test_p3_f5();
    bit to;
    run_job(3, 5, 16'h0010, 16'h0040, 1'b0, 1'b0, to);
    n_checks++; if (to) begin n_fail++; $display("FAIL p3f5_timeout: got timeout required done"); end
    n_checks++;
    if (seq_log.size() != 20) begin n_fail++; $display("FAIL p3f5_nwords: got %0d required 20", seq_log.size()); end
    for (int i = 0; i < 20; i++) begin
      n_checks++;
      if (seq_log[i] !== {1'(i >= 12), 16'h0000, exp_addr(3, 16'h0010, 16'h0040, i)}) begin
        n_fail++;
        $display("FAIL p3f5_word[%0d]: got %h required %h", i, seq_log[i],
                 {1'(i >= 12), 16'h0000, exp_addr(3, 16'h0010, 16'h0040, i)});
      end
    end
  endtask

  task automatic test_backpressure();
    bit to;
    run_job(3, 5, 16'h0010, 16'h0040, 1'b1, 1'b0, to);
    n_checks++; if (to) begin n_fail++; $display("FAIL bp_timeout: got timeout required done"); end
    n_checks++;
    if (seq_log.size() != 20) begin n_fail++; $display("FAIL bp_nwords: got %0d required 20", seq_log.size()); end
    for (int i = 0; i < 20; i++) begin
      n_checks++;
      if (seq_log[i] !== {1'(i >= 12), 16'h0000, exp_addr(3, 16'h0010, 16'h0040, i)}) begin
        n_fail++;
        $display("FAIL bp_word[%0d]: got %h required %h", i, seq_log[i],
                 {1'(i >= 12), 16'h0000, exp_addr(3, 16'h0010, 16'h0040, i)});
      end
    end
    n_checks++;
    if (stab_err != 0) begin n_fail++; $display("FAIL bp_stability: got %0d violations required 0", stab_err); end
    n_checks++;
    if (ovf_err != 0) begin n_fail++; $display("FAIL bp_fifo_level: got %0d cycles above 2 required 0", ovf_err); end
    n_checks++;
    if (addr_log.size() != 20) begin n_fail++; $display("FAIL bp_nreads: got %0d required 20", addr_log.size()); end
  endtask

  task automatic test_wrap();
    bit to;
    run_job(0, 0, 16'hFFFE, 16'h0100, 1'b0, 1'b0, to);
    n_checks++; if (to) begin n_fail++; $display("FAIL wrap_timeout: got timeout required done"); end
    for (int i = 0; i < 6; i++) begin
      n_checks++;
      if (addr_log[i] !== exp_addr(0, 16'hFFFE, 16'h0100, i)) begin
        n_fail++;
        $display("FAIL wrap_addr[%0d]: got %h required %h", i, addr_log[i], exp_addr(0, 16'hFFFE, 16'h0100, i));
      end
    end
  endtask

  task automatic test_start_while_busy();
    bit to;
    run_job(0, 0, 16'h0010, 16'h0040, 1'b0, 1'b1, to);
    n_checks++; if (to) begin n_fail++; $display("FAIL busy_start_timeout: got timeout required done"); end
    for (int i = 0; i < 6; i++) begin
      n_checks++;
      if (addr_log[i] !== exp_addr(0, 16'h0010, 16'h0040, i)) begin
        n_fail++;
        $display("FAIL busy_start_addr[%0d]: got %h required %h", i, addr_log[i], exp_addr(0, 16'h0010, 16'h0040, i));
      end
    end
    repeat (5) @(posedge clk);
    #1;
    n_checks++;
    if (busy !== 1'b0 || addr_log.size() != 6 || done_cnt != 1) begin
      n_fail++;
      $display("FAIL busy_start_ignored: got busy=%b reads=%0d done_cnt=%0d required 0/6/1", busy, addr_log.size(), done_cnt);
    end
  endtask

  task automatic test_back_to_back();
    bit seen;
    int d0;
    bit to;
    clear_logs();
    i_config = 12'h000; filt_base = 16'h0010; ifmap_base = 16'h0040; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 100 && !seen; k++) begin
      if (done === 1'b1) seen = 1'b1;
      else begin @(posedge clk); #1; end
    end
    n_checks++; if (!seen) begin n_fail++; $display("FAIL b2b_first_done: got no done required done"); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL b2b_busy_in_done: got %b required 0", busy); end
    clear_logs();
    i_config = {2'd1, 2'd0, 8'd1}; filt_base = 16'h0020; ifmap_base = 16'h0050; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL b2b_accepted: got busy=%b required 1", busy); end
    d0 = done_cnt; to = 1'b1;
    for (int k = 0; k < 200; k++) begin
      if (done_cnt > d0) begin to = 1'b0; break; end
      @(posedge clk); #1;
    end
    n_checks++; if (to) begin n_fail++; $display("FAIL b2b_timeout: got timeout required done"); end
    n_checks++;
    if (addr_log.size() != 10) begin n_fail++; $display("FAIL b2b_nreads: got %0d required 10", addr_log.size()); end
    for (int i = 0; i < 10; i++) begin
      n_checks++;
      if (addr_log[i] !== exp_addr(1, 16'h0020, 16'h0050, i)) begin
        n_fail++;
        $display("FAIL b2b_addr[%0d]: got %h required %h", i, addr_log[i], exp_addr(1, 16'h0020, 16'h0050, i));
      end
    end
  endtask

  task automatic test_reset_mid();
    bit reached, to;
    clear_logs();
    i_config = {2'd3, 2'd0, 8'd5}; filt_base = 16'h0010; ifmap_base = 16'h0040; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    reached = 1'b0;
    for (int k = 0; k < 200 && !reached; k++) begin
      if (seq_log.size() >= 14) reached = 1'b1;
      else begin @(posedge clk); #1; end
    end
    n_checks++; if (!reached) begin n_fail++; $display("FAIL rstmid_reach_ifmap: got %0d words required 14", seq_log.size()); end
    rst = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if ({glb_rd_en, glb_addr, filter, filter_valid, ifmap, ifmap_valid, busy, done} !== '0) begin
      n_fail++;
      $display("FAIL rstmid_outputs: got rd=%b addr=%h f=%h fv=%b i=%h iv=%b busy=%b done=%b required all 0",
               glb_rd_en, glb_addr, filter, filter_valid, ifmap, ifmap_valid, busy, done);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if ({busy, filter_valid, ifmap_valid} !== 3'b000) begin
      n_fail++; $display("FAIL rstmid_idle: got busy=%b fv=%b iv=%b required 0", busy, filter_valid, ifmap_valid);
    end
    run_job(3, 5, 16'h0010, 16'h0040, 1'b0, 1'b0, to);
    n_checks++; if (to) begin n_fail++; $display("FAIL rstmid_replay_timeout: got timeout required done"); end
    n_checks++;
    if (seq_log.size() != 20) begin n_fail++; $display("FAIL rstmid_nwords: got %0d required 20", seq_log.size()); end
    for (int i = 0; i < 20; i++) begin
      n_checks++;
      if (seq_log[i] !== {1'(i >= 12), 16'h0000, exp_addr(3, 16'h0010, 16'h0040, i)}) begin
        n_fail++;
        $display("FAIL rstmid_word[%0d]: got %h required %h", i, seq_log[i],
                 {1'(i >= 12), 16'h0000, exp_addr(3, 16'h0010, 16'h0040, i)});
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_p3_f5();
    test_backpressure();
    test_wrap();
    test_start_while_busy();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pe_stream_feeder.md
Name: pe_stream_feeder

Overview:
- Transmit side of the PE input protocol: reads packed filter and ifmap words from the global buffer (GLB) and streams them to one PE over valid/ready.
- Word order matches the PE's receive state machine: all filter words first, then a 3-word ifmap preload, then one ifmap word per F step.
- Sits between the GLB read port and a PE's filter/ifmap inputs. ipsum/opsum handling belongs elsewhere.

Parameters:
- ADDR_W, 16, GLB word-address width.
- DATA_BITS, 32, word width: 4 packed 8-bit channel lanes, q lane at bits [8q+7:8q].
- FIFO_DEPTH, 2, skid-FIFO entries. Fixed at 2; other values unsupported.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse; latches cfg and bases. Ignored while busy=1.
- i_config  in  12  [11:10]=p (PE count-1), [9:8]=q (unused here, latched only), [7:0]=F (ifmap steps after preload).
- filt_base  in  ADDR_W  GLB address of filter word 0.
- ifmap_base  in  ADDR_W  GLB address of ifmap word 0.
- glb_rd_en  out  1  read request.
- glb_addr  out  ADDR_W  read address.
- glb_rdata  in  DATA_BITS  read data, valid exactly 1 cycle after glb_rd_en.
- filter  out  DATA_BITS  filter word to PE.
- filter_valid  out  1
- filter_ready  in  1
- ifmap  out  DATA_BITS  ifmap word to PE, raw and unsigned; the PE applies the XOR 0x80.
- ifmap_valid  out  1
- ifmap_ready  in  1
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse after the last ifmap handshake.

Behaviour:
- Reset values: all outputs 0. FIFO empty, counters 0, state IDLE.
- States:
  - IDLE: on start, latch p, F, filt_base, ifmap_base. Go to FILT.
  - FILT: issue filter reads. After 3*(p+1) requests, go to IF.
  - IF: issue ifmap reads. After 3+F requests, go to DRAIN.
  - DRAIN: wait until FIFO is empty and no read is in flight. Then pulse done and go to IDLE.
- Filter address order: word index k = 3*pi + s, with pi in 0..p outer and s in 0..2 inner. glb_addr = filt_base + k.
- Ifmap address order: ifmap_base + j, j in 0..2+F.
- Address arithmetic is modulo 2^ADDR_W (wraps silently).
- Read issue rule: glb_rd_en=1 in FILT/IF only when fifo_count + inflight + 1 <= 2 after counting any pop this cycle. inflight is 0 or 1.
- Read data path:
  - Each returned word is pushed the cycle it arrives, tagged 0 = filter, 1 = ifmap.
  - The FIFO can never overflow.
  - Push and pop in the same cycle are both honoured.
- Output routing from the FIFO head:
  - filter_valid = nonempty & tag==0.
  - ifmap_valid = nonempty & tag==1.
  - filter and ifmap carry head data. The inactive port's valid is 0.
  - Pop on (filter_valid & filter_ready) | (ifmap_valid & ifmap_ready).
- Valid/data stability: once a valid is high, it and its data hold until the handshake.
- Latency: first filter_valid appears 3 cycles after start (latch, read, data).
- Throughput: back-to-back handshakes at 1 word/cycle when ready stays high.
- Backpressure: ready low for any duration causes no loss or duplication. Reads stall after the FIFO fills.
- F=0: ifmap sends exactly 3 words. p=0: filter sends exactly 3 words.
- Tag transition: the last filter word and the first ifmap word may sit in the FIFO together. Ifmap is never presented before the filter head pops.
- done/busy: done is asserted in the cycle after the final ifmap pop. busy falls in the same cycle. A start during that cycle is honoured.
- Reset mid-operation: immediate return to IDLE. FIFO flushed, in-flight data discarded, outputs 0.

Decomposition:
- Shared package/define header:
  - DATA_BITS and CONFIG_SIZE (12).
  - Config field offsets: p [11:10], q [9:8], F [7:0].
  - FIFO tag encodings: TAG_FILT = 0, TAG_IFMAP = 1.
  - State encodings.
- Sub-module: feeder_skid_fifo, 2 entries × (1 tag bit + DATA_BITS), with push/pop/count.

Test Plan:
- p=0, F=0, filt_base=0x10, ifmap_base=0x40, readies tied high:
  - Expect reads 0x10..0x12, then 0x40..0x42.
  - Expect exactly 3 filter handshakes, then 3 ifmap handshakes, in order.
  - Expect done exactly once, busy low afterward.
- p=3, F=5, GLB[a]=a:
  - Expect 12 filter words with data 0x10..0x1B, in order pi outer / s inner.
  - Expect 8 ifmap words with data 0x40..0x47.
- Same config, ready toggled pseudo-randomly and held low 10 cycles mid-filter and mid-ifmap:
  - Expect identical word sequence, no gaps or duplicates.
  - Expect valid and data stable while ready is low.
  - Expect the FIFO never above 2 entries.
- filt_base=0xFFFE, p=0:
  - Expect addresses 0xFFFE, 0xFFFF, 0x0000.
- A start pulse asserted while busy:
  - Expect it ignored.
- Reset asserted during the ifmap phase:
  - Expect all outputs 0 next edge.
  - Expect a new start to replay the full sequence from filter word 0.
